// File: rtl/fetch_pc_ctrl_if.sv
// Redirect handshake between the execute-stage target adder (master) and the fetch PC controller (slave).
interface fetch_pc_ctrl_if;
    logic        redirect_valid_in;
    logic [31:0] redirect_target_in;
    logic        redirect_ready_out;

    modport master (
        output redirect_valid_in,
        output redirect_target_in,
        input  redirect_ready_out
    );

    modport slave (
        input  redirect_valid_in,
        input  redirect_target_in,
        output redirect_ready_out
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: advances PC, applies redirects over stalls, pulses a multi-cycle flush.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pc_ctrl_if.slave        redir,
    input  logic                  stall_in,
    output logic [31:0]           pc_out,
    output logic [31:0]           pc_plus4_out,
    output logic                  fetch_valid_out,
    output logic                  flush_out,
    output logic                  trap_out,
    output logic [31:0]           epc_out
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned PC_W  = 32;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..7");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc4_q, pc4_d;
    logic              fv_q;
    logic              flush_q, flush_d;
    logic              accept;
    logic [PC_W-1:0]   tgt_eff;

    assign accept = redir.redirect_valid_in && redir.redirect_ready_out;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: flush counter runs regardless of stall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs / datapath: accepted redirect wins over stall
    always_comb begin
        redir.redirect_ready_out = (state_q == RUN);
        flush_d                  = (state_d == FLUSH);
        pc_d                     = pc_q;
        if (accept) begin
            pc_d = tgt_eff;
        end else if (!stall_in) begin
            pc_d = pc_q + PC_W'(4);
        end
        pc4_d = pc_d + PC_W'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            pc4_q   <= RESET_VECTOR + PC_W'(4);
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            fv_q    <= 1'b1;
            flush_q <= flush_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misaligned;
    logic            trap_q;
    logic [PC_W-1:0] epc_q;

    assign misaligned = |redir.redirect_target_in[1:0];
    assign tgt_eff    = misaligned ? TRAP_VECTOR : redir.redirect_target_in;

    // Trap pulse and sticky faulting target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
            epc_q  <= '0;
        end else begin
            trap_q <= accept && misaligned;
            if (accept && misaligned) begin
                epc_q <= redir.redirect_target_in;
            end
        end
    end

    assign trap_out = trap_q;
    assign epc_out  = epc_q;
`else
    assign tgt_eff  = redir.redirect_target_in & ~PC_W'(3);
    assign trap_out = 1'b0;
    assign epc_out  = '0;
`endif

    assign pc_out          = pc_q;
    assign pc_plus4_out    = pc4_q;
    assign fetch_valid_out = fv_q;
    assign flush_out       = flush_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl (default FLUSH_CYCLES=2, vectors 0x0/0x100).
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic [31:0] pc_out, pc_plus4_out, epc_out;
    logic        fetch_valid_out, flush_out, trap_out;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    fetch_pc_ctrl_if rif ();

    fetch_pc_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redir           (rif),
        .stall_in        (stall_in),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .fetch_valid_out (fetch_valid_out),
        .flush_out       (flush_out),
        .trap_out        (trap_out),
        .epc_out         (epc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pc, flush, ready packed for compact compares
    function automatic logic [33:0] obs();
        return {pc_out, flush_out, rif.redirect_ready_out};
    endfunction

    task automatic test_reset();
        logic [33:0] e;
        rst = 1'b1; stall_in = 1'b0;
        rif.redirect_valid_in = 1'b0; rif.redirect_target_in = '0;
        repeat (3) tick();
        total_cnt++;
        if ({pc_out, pc_plus4_out, fetch_valid_out, flush_out, rif.redirect_ready_out, trap_out, epc_out}
            !== {32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0})
            $display("FAIL reset_values pc=%h pc4=%h fv=%b fl=%b rdy=%b trap=%b epc=%h",
                     pc_out, pc_plus4_out, fetch_valid_out, flush_out, rif.redirect_ready_out, trap_out, epc_out);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            e = {32'(i * 4), 1'b0, 1'b1};
            total_cnt++;
            if ({obs(), pc_plus4_out, fetch_valid_out} !== {e, 32'(i * 4 + 4), 1'b1})
                $display("FAIL run_seq%0d got pc=%h pc4=%h fv=%b exp pc=%h pc4=%h fv=1",
                         i, pc_out, pc_plus4_out, fetch_valid_out, 32'(i * 4), 32'(i * 4 + 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        logic [33:0] exp_v [5];
        exp_v[0] = {32'h40, 1'b1, 1'b0};
        exp_v[1] = {32'h44, 1'b1, 1'b0};
        exp_v[2] = {32'h48, 1'b0, 1'b1};
        exp_v[3] = {32'h80, 1'b1, 1'b0};
        exp_v[4] = {32'h84, 1'b1, 1'b0};
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) rif.redirect_target_in = 32'h80;
            if (i == 3) rif.redirect_valid_in = 1'b0;
            total_cnt++;
            if (obs() !== exp_v[i])
                $display("FAIL redirect_step%0d got {pc,fl,rdy}=%h exp %h", i, obs(), exp_v[i]);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (obs() !== {32'h88, 1'b0, 1'b1})
            $display("FAIL redirect_end got {pc,fl,rdy}=%h exp %h", obs(), {32'h88, 1'b0, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_stall();
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'h20;
        tick();
        rif.redirect_valid_in = 1'b0; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (obs() !== {32'h20, (i == 0), (i != 0)})
                $display("FAIL stall_hold%0d got {pc,fl,rdy}=%h exp %h", i, obs(), {32'h20, (i == 0), (i != 0)});
            else pass_cnt++;
        end
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'h100;
        tick();
        rif.redirect_valid_in = 1'b0; stall_in = 1'b0;
        total_cnt++;
        if (obs() !== {32'h100, 1'b1, 1'b0})
            $display("FAIL stall_redirect got {pc,fl,rdy}=%h exp %h", obs(), {32'h100, 1'b1, 1'b0});
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if (obs() !== {32'h108, 1'b0, 1'b1})
            $display("FAIL stall_resume got {pc,fl,rdy}=%h exp %h", obs(), {32'h108, 1'b0, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'hFFFF_FFF8;
        tick();
        rif.redirect_valid_in = 1'b0;
        total_cnt++;
        if ({pc_out, pc_plus4_out} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC})
            $display("FAIL wrap_load got pc=%h pc4=%h exp fffffff8/fffffffc", pc_out, pc_plus4_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({pc_out, pc_plus4_out} !== {32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_top got pc=%h pc4=%h exp fffffffc/00000000", pc_out, pc_plus4_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({pc_out, pc_plus4_out, flush_out} !== {32'h0, 32'h4, 1'b0})
            $display("FAIL wrap_zero got pc=%h pc4=%h fl=%b exp 0/4/0", pc_out, pc_plus4_out, flush_out);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
`ifdef FETCH_MISALIGN_TRAP_EN
        logic [31:0] base = 32'h100; logic [31:0] epc_e = 32'h42; logic trap_e = 1'b1;
`else
        logic [31:0] base = 32'h40;  logic [31:0] epc_e = 32'h0;  logic trap_e = 1'b0;
`endif
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'h42;
        tick();
        rif.redirect_valid_in = 1'b0;
        total_cnt++;
        if ({obs(), trap_out, epc_out} !== {base, 1'b1, 1'b0, trap_e, epc_e})
            $display("FAIL misalign_accept got pc=%h fl=%b trap=%b epc=%h exp pc=%h fl=1 trap=%b epc=%h",
                     pc_out, flush_out, trap_out, epc_out, base, trap_e, epc_e);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({obs(), trap_out, epc_out} !== {base + 32'h4, 1'b1, 1'b0, 1'b0, epc_e})
            $display("FAIL misalign_next got pc=%h fl=%b trap=%b epc=%h exp pc=%h fl=1 trap=0 epc=%h",
                     pc_out, flush_out, trap_out, epc_out, base + 32'h4, epc_e);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({obs(), trap_out, epc_out} !== {base + 32'h8, 1'b0, 1'b1, 1'b0, epc_e})
            $display("FAIL misalign_end got pc=%h fl=%b trap=%b epc=%h exp pc=%h fl=0 trap=0 epc=%h",
                     pc_out, flush_out, trap_out, epc_out, base + 32'h8, epc_e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_flush();
        rif.redirect_valid_in = 1'b1; rif.redirect_target_in = 32'h200;
        tick();
        rif.redirect_valid_in = 1'b0;
        total_cnt++;
        if (obs() !== {32'h200, 1'b1, 1'b0})
            $display("FAIL rstflush_pre got {pc,fl,rdy}=%h exp %h", obs(), {32'h200, 1'b1, 1'b0});
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({pc_out, pc_plus4_out, fetch_valid_out, flush_out, rif.redirect_ready_out, trap_out, epc_out}
            !== {32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0})
            $display("FAIL rstflush_async pc=%h pc4=%h fv=%b fl=%b rdy=%b trap=%b epc=%h",
                     pc_out, pc_plus4_out, fetch_valid_out, flush_out, rif.redirect_ready_out, trap_out, epc_out);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({obs(), fetch_valid_out} !== {32'h0, 1'b0, 1'b1, 1'b0})
            $display("FAIL rstflush_release got {pc,fl,rdy,fv}=%h exp %h", {obs(), fetch_valid_out}, {32'h0, 1'b0, 1'b1, 1'b0});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({obs(), fetch_valid_out} !== {32'h4, 1'b0, 1'b1, 1'b1})
            $display("FAIL rstflush_restart got {pc,fl,rdy,fv}=%h exp %h", {obs(), fetch_valid_out}, {32'h4, 1'b0, 1'b1, 1'b1});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_wrap();
        test_misalign();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
